// File: rtl/hidden_layer_pkg.sv
// rtl/hidden_layer_pkg.sv - shared sizes, weight-file layout and FSM states for the hidden layer
package hidden_layer_pkg;
  localparam int N_IN   = 10;
  localparam int N_HID  = 5;
  localparam int DW     = 10;
  localparam int ACC_W  = 26;
  localparam int NWT    = N_HID * (N_IN + 3);
  localparam int PROD_W = 2 * DW + 1;
  localparam int NROW   = (NWT + N_IN - 1) / N_IN;

  localparam int WB = 0;
  localparam int BB = WB + N_HID * N_IN;
  localparam int TB = BB + N_HID;
  localparam int RB = TB + N_HID;

  localparam logic [DW-1:0] W_DEFAULT = DW'(1);

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  // Weights power up as 1, biases/thresholds/reserved as 0.
  function automatic logic [DW-1:0] default_weight(input int e);
    return (e < BB) ? W_DEFAULT : '0;
  endfunction
endpackage

// File: rtl/hl_neuron_mac.sv
// rtl/hl_neuron_mac.sv - one step-activation neuron: serial signed MAC plus bias/threshold compare
module hl_neuron_mac
  import hidden_layer_pkg::*;
(
  input  logic          Clock,
  input  logic          Rst,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] bias,
  input  logic [DW-1:0] thr,
  output logic          fire
);
  logic signed [ACC_W-1:0]  acc_q, acc_d, biased;
  logic signed [PROD_W-1:0] prod;

  // x is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    prod   = PROD_W'($signed(w)) * PROD_W'($signed({1'b0, x}));
    acc_d  = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
    biased = acc_q + ACC_W'($signed(bias));
  end

  assign fire = biased > ACC_W'($signed(thr));

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/hidden_layer.sv
// rtl/hidden_layer.sv - 10-input, 5-neuron hidden layer with loadable weight file and serial compute
module hidden_layer
  import hidden_layer_pkg::*;
(
  input  logic          Clock,
  input  logic          Rst,
  input  logic          WE,
  input  logic          In,
  input  logic [DW-1:0] inVal  [0:N_IN-1],
  output logic          outVal [0:N_HID-1],
  output logic [DW-1:0] weight [0:NWT-1]
);
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    wptr_q, wptr_d;
  logic [DW-1:0] x_q      [0:N_IN-1];
  logic [DW-1:0] weight_q [0:NWT-1];
  logic          out_q    [0:N_HID-1];
  logic          wr, start, mac_en, fin;
  logic [DW-1:0] x_sel;
  logic [DW-1:0] w_sel    [0:N_HID-1];
  logic          fire     [0:N_HID-1];

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    start   = 1'b0;
    mac_en  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (WE) begin
          wr = 1'b1;
        end else if (In) begin
          start   = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == 4'(N_IN - 1)) state_d = FIN;
      end
      FIN: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (start) begin
      idx_d = '0;
    end else if (mac_en) begin
      idx_d = (idx_q == 4'(N_IN - 1)) ? 4'd0 : idx_q + 4'd1;
    end
    wptr_d = wptr_q;
    if (wr) wptr_d = (wptr_q == 3'(NROW - 1)) ? 3'd0 : wptr_q + 3'd1;
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
    end
  end

  // The last row only covers the reserved entries, so writes past NWT fall away.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int e = 0; e < NWT; e++) weight_q[e] <= default_weight(e);
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      for (int n = 0; n < N_HID; n++) out_q[n] <= 1'b0;
    end else begin
      if (start) x_q <= inVal;
      if (wr) begin
        for (int e = 0; e < NWT; e++) begin
          if (wptr_q == 3'(e / N_IN)) weight_q[e] <= inVal[e % N_IN];
        end
      end
      if (fin) out_q <= fire;
    end
  end

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == 4'(i)) x_sel = x_q[i];
    end
    for (int n = 0; n < N_HID; n++) begin
      w_sel[n] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (idx_q == 4'(i)) w_sel[n] = weight_q[WB + n * N_IN + i];
      end
    end
  end

  for (genvar n = 0; n < N_HID; n++) begin : g_neuron
    hl_neuron_mac u_mac (
      .Clock (Clock),
      .Rst   (Rst),
      .clear (start),
      .en    (mac_en),
      .x     (x_sel),
      .w     (w_sel[n]),
      .bias  (weight_q[BB + n]),
      .thr   (weight_q[TB + n]),
      .fire  (fire[n])
    );
  end

  assign outVal = out_q;
  assign weight = weight_q;
endmodule

// File: tb/tb_hidden_layer.sv
// tb/tb_hidden_layer.sv - directed bench for hidden_layer with an arithmetic reference model
module tb_hidden_layer;
  import hidden_layer_pkg::*;

  logic          Clock = 1'b0;
  logic          Rst   = 1'b1;
  logic          WE    = 1'b0;
  logic          In    = 1'b0;
  logic [DW-1:0] inVal  [0:N_IN-1];
  logic          outVal [0:N_HID-1];
  logic [DW-1:0] weight [0:NWT-1];

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  int         mw [0:64];
  int         mx [0:9];
  int         mwptr;
  int         mcnt;
  logic [4:0] mout;

  hidden_layer dut (
    .Clock  (Clock),
    .Rst    (Rst),
    .WE     (WE),
    .In     (In),
    .inVal  (inVal),
    .outVal (outVal),
    .weight (weight)
  );

  always #5 Clock = ~Clock;

  function automatic logic [4:0] ov();
    logic [4:0] r;
    for (int n = 0; n < 5; n++) r[4-n] = outVal[n];
    return r;
  endfunction

  // Neuron n fires when sum(w*x) + bias > thr, all in plain integers.
  function automatic logic [4:0] eval_model();
    logic [4:0] r;
    int s;
    for (int n = 0; n < 5; n++) begin
      s = mw[50 + n];
      for (int i = 0; i < 10; i++) s += mw[10 * n + i] * mx[i];
      r[4-n] = (s > mw[55 + n]);
    end
    return r;
  endfunction

  always @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int e = 0; e < 65; e++) mw[e] <= (e < 50) ? 1 : 0;
      for (int i = 0; i < 10; i++) mx[i] <= 0;
      mwptr <= 0;
      mcnt  <= 0;
      mout  <= 5'b0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mout <= eval_model();
    end else if (WE) begin
      for (int i = 0; i < 10; i++) begin
        if (10 * mwptr + i < 65) mw[10 * mwptr + i] <= int'($signed(inVal[i]));
      end
      mwptr <= (mwptr + 1) % 7;
    end else if (In) begin
      for (int i = 0; i < 10; i++) mx[i] <= int'(inVal[i]);
      mcnt <= 11;
    end
  end

  task automatic chk_o(input string nm, input logic [4:0] act, input logic [4:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [9:0] act, input logic [9:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_loop();
    int bad;
    forever begin
      @(negedge Clock);
      if (chk_on) begin
        chk_o("outVal_vs_model", ov(), mout);
        bad = -1;
        for (int e = 0; e < 65; e++) begin
          if (bad < 0 && weight[e] !== 10'(mw[e])) bad = e;
        end
        if (bad >= 0) chk_w($sformatf("weight[%0d]_vs_model", bad), weight[bad], 10'(mw[bad]));
        else          chk_w("weight_file_vs_model", weight[0], 10'(mw[0]));
      end
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic set_all(input logic [9:0] v);
    for (int i = 0; i < 10; i++) inVal[i] = v;
  endtask

  task automatic pulse_we();
    WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic run_pass(input logic [4:0] exp, input string nm);
    In = 1'b1;
    tick();
    In = 1'b0;
    repeat (11) tick();
    chk_o(nm, ov(), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    set_all(10'd1);
    fork
      cmp_loop();
    join_none
    Rst = 1'b1;
    tick();
    tick();
    chk_on = 1'b1;
    chk_o("reset_outVal", ov(), 5'b00000);
    chk_w("reset_w0", weight[0], 10'd1);
    chk_w("reset_w49", weight[49], 10'd1);
    chk_w("reset_w50", weight[50], 10'd0);
    chk_w("reset_w64", weight[64], 10'd0);
    Rst = 1'b0;
    tick();

    run_pass(5'b11111, "default_pass");

    set_all(10'h3FF);
    WE = 1'b1;
    In = 1'b1;
    tick();
    WE = 1'b0;
    In = 1'b0;
    chk_w("we_over_in_w0", weight[0], 10'h3FF);
    repeat (12) tick();
    chk_o("we_over_in_no_pass", ov(), 5'b11111);
    set_all(10'd1);
    repeat (4) pulse_we();
    set_all(10'd0);
    repeat (2) pulse_we();
    set_all(10'd1);
    run_pass(5'b01111, "loaded_pass");

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
    set_all(10'd1);
    repeat (5) pulse_we();
    set_all(10'd0);
    inVal[6] = 10'd10;
    pulse_we();
    chk_w("thr1_written", weight[56], 10'd10);
    set_all(10'd1);
    run_pass(5'b10111, "thr1_eq_acc");
    set_all(10'd0);
    pulse_we();
    set_all(10'd1);
    repeat (5) pulse_we();
    set_all(10'd0);
    inVal[1] = 10'd1;
    inVal[6] = 10'd10;
    pulse_we();
    set_all(10'd1);
    run_pass(5'b11111, "bias1_tips_over");

    In = 1'b1;
    tick();
    In = 1'b0;
    tick();
    tick();
    set_all(10'd7);
    WE = 1'b1;
    tick();
    WE = 1'b0;
    set_all(10'd0);
    repeat (8) tick();
    chk_o("we_in_mac_out", ov(), 5'b11111);
    chk_w("we_in_mac_w60", weight[60], 10'd0);
    set_all(10'd7);
    pulse_we();
    chk_w("wptr_held_w60", weight[60], 10'd7);
    chk_w("wptr_held_w0", weight[0], 10'd1);

    set_all(10'd1);
    In = 1'b1;
    tick();
    In = 1'b0;
    repeat (5) tick();
    Rst = 1'b1;
    #1;
    chk_o("midreset_out", ov(), 5'b00000);
    chk_w("midreset_w56", weight[56], 10'd0);
    chk_w("midreset_w60", weight[60], 10'd0);
    tick();
    Rst = 1'b0;
    tick();
    run_pass(5'b11111, "after_midreset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
